// File: rtl/serial_receiver.sv
// Five-lane serial link receiver: deframes header + four data lanes, checks parity,
// decodes packet type and drives ACK/garbage/game-data handshakes with duplicate filtering.
module serial_receiver #(
    parameter int LANE_BITS = 64,
    parameter int GBG_W     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   serial_in_h,
    input  logic                   serial_in_0,
    input  logic                   serial_in_1,
    input  logic                   serial_in_2,
    input  logic                   serial_in_3,
    output logic                   ready_received,
    output logic                   game_lost_received,
    output logic                   ack_received,
    output logic                   ack_seqNum,
    output logic                   garbage_valid,
    output logic [GBG_W-1:0]       garbage,
    output logic                   data_valid,
    output logic [4*LANE_BITS-1:0] payload,
    output logic                   send_ack,
    output logic                   send_ack_seqNum,
    output logic                   rx_error,
    output logic [7:0]             error_count
);

    localparam int PW    = 4 * LANE_BITS;
    localparam int CNT_W = $clog2(LANE_BITS + 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LANE_BITS + 1);
    localparam logic [CNT_W-1:0] HDR_END  = CNT_W'(5);

    typedef enum logic {IDLE, RECV} state_t;
    typedef enum logic [2:0] {
        T_READY     = 3'd1,
        T_GAME_LOST = 3'd2,
        T_ACK       = 3'd3,
        T_GARBAGE   = 3'd4,
        T_GAME_DATA = 3'd5
    } ptype_t;

    state_t state, state_nxt;

    logic [4:0]                meta, sync;
    logic [CNT_W-1:0]          cnt;
    logic [4:0]                hdr;
    logic [3:0][LANE_BITS-1:0] lanes;
    logic [PW-1:0]             lanes_flat;
    logic                      last_seq, seq_valid;

    logic       last_bit, hdr_ok, type_ok, frame_ok, dup;
    logic [3:0] lane_ok;
    logic [2:0] ptype;
    logic       pseq;

    // sync[4] is the header lane, sync[3:0] the data lanes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= {serial_in_h, serial_in_3, serial_in_2, serial_in_1, serial_in_0};
            sync <= meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (sync[4]) state_nxt = RECV;
            RECV: if (cnt == LAST_CNT) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            hdr   <= '0;
            lanes <= '0;
        end else if (state == IDLE) begin
            if (sync[4]) cnt <= CNT_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt <= HDR_END) hdr <= {hdr[3:0], sync[4]};
            // Lane parity bits are consumed live in the last cycle, never shifted in
            if (cnt != LAST_CNT) begin
                for (int unsigned k = 0; k < 4; k++)
                    lanes[k] <= {lanes[k][LANE_BITS-2:0], sync[k]};
            end
        end
    end

    always_comb begin
        lanes_flat = lanes;
        ptype      = hdr[4:2];
        pseq       = hdr[1];
        hdr_ok     = ~^hdr;
        for (int unsigned k = 0; k < 4; k++)
            lane_ok[k] = ~^{lanes[k], sync[k]};
        type_ok  = (ptype >= 3'd1) && (ptype <= 3'd5);
        frame_ok = hdr_ok && (&lane_ok) && type_ok;
        dup      = seq_valid && (pseq == last_seq);
        last_bit = (state == RECV) && (cnt == LAST_CNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_received     <= 1'b0;
            game_lost_received <= 1'b0;
            ack_received       <= 1'b0;
            ack_seqNum         <= 1'b0;
            garbage_valid      <= 1'b0;
            garbage            <= '0;
            data_valid         <= 1'b0;
            payload            <= '0;
            send_ack           <= 1'b0;
            send_ack_seqNum    <= 1'b0;
            rx_error           <= 1'b0;
            error_count        <= '0;
            last_seq           <= 1'b0;
            seq_valid          <= 1'b0;
        end else begin
            ready_received     <= 1'b0;
            game_lost_received <= 1'b0;
            ack_received       <= 1'b0;
            garbage_valid      <= 1'b0;
            data_valid         <= 1'b0;
            send_ack           <= 1'b0;
            rx_error           <= 1'b0;
            if (last_bit) begin
                if (!frame_ok) begin
                    rx_error <= 1'b1;
                    if (error_count != 8'hFF) error_count <= error_count + 8'd1;
                end else begin
                    case (ptype)
                        T_READY:     ready_received     <= 1'b1;
                        T_GAME_LOST: game_lost_received <= 1'b1;
                        T_ACK: begin
                            ack_received <= 1'b1;
                            ack_seqNum   <= pseq;
                        end
                        T_GARBAGE, T_GAME_DATA: begin
                            send_ack        <= 1'b1;
                            send_ack_seqNum <= pseq;
                            if (!dup) begin
                                if (ptype == T_GARBAGE) begin
                                    garbage       <= lanes_flat[GBG_W-1:0];
                                    garbage_valid <= 1'b1;
                                end else begin
                                    payload    <= lanes_flat;
                                    data_valid <= 1'b1;
                                end
                                last_seq  <= pseq;
                                seq_valid <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver (LANE_BITS=8): frames are driven on the pins,
// pulses are expected exactly 12 pin-cycles after the start bit.
module tb_serial_receiver;

    localparam int LB = 8;

    localparam logic [6:0] P_NONE  = 7'b0000000;
    localparam logic [6:0] P_READY = 7'b1000000;
    localparam logic [6:0] P_GL    = 7'b0100000;
    localparam logic [6:0] P_ACK   = 7'b0010000;
    localparam logic [6:0] P_GV    = 7'b0001000;
    localparam logic [6:0] P_DV    = 7'b0000100;
    localparam logic [6:0] P_SA    = 7'b0000010;
    localparam logic [6:0] P_ERR   = 7'b0000001;

    logic          clk = 1'b0;
    logic          rst;
    logic          sh, s0, s1, s2, s3;
    logic          ready_received, game_lost_received, ack_received, ack_seqNum;
    logic          garbage_valid, data_valid, send_ack, send_ack_seqNum, rx_error;
    logic [3:0]    garbage;
    logic [4*LB-1:0] payload;
    logic [7:0]    error_count;
    logic [6:0]    pulses;

    int errors = 0;
    int checks = 0;
    logic [6:0] snap1, snap2, snap3;
    logic [3:0] snap_gbg;

    serial_receiver #(.LANE_BITS(LB), .GBG_W(4)) dut (
        .clk(clk), .rst(rst),
        .serial_in_h(sh), .serial_in_0(s0), .serial_in_1(s1),
        .serial_in_2(s2), .serial_in_3(s3),
        .ready_received(ready_received), .game_lost_received(game_lost_received),
        .ack_received(ack_received), .ack_seqNum(ack_seqNum),
        .garbage_valid(garbage_valid), .garbage(garbage),
        .data_valid(data_valid), .payload(payload),
        .send_ack(send_ack), .send_ack_seqNum(send_ack_seqNum),
        .rx_error(rx_error), .error_count(error_count)
    );

    always #10 clk = ~clk;

    assign pulses = {ready_received, game_lost_received, ack_received,
                     garbage_valid, data_valid, send_ack, rx_error};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_pins(input logic h, input logic [3:0] d);
        sh = h;
        {s3, s2, s1, s0} = d;
    endtask

    // Drives pin-cycles 0..ncyc-1 of a frame; snapshots outputs at cycles 1..3 so a
    // back-to-back predecessor's pulse can be checked afterwards.
    task automatic send_frame(input logic [2:0] typ, input logic sq, input logic [31:0] pl,
                              input logic [4:0] flip, input int ncyc);
        logic       h;
        logic [3:0] d;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (c == 1) snap1 = pulses;
            if (c == 2) begin snap2 = pulses; snap_gbg = garbage; end
            if (c == 3) snap3 = pulses;
            h = 1'b0;
            d = 4'b0000;
            case (c)
                0: h = 1'b1;
                1: h = typ[2];
                2: h = typ[1];
                3: h = typ[0];
                4: h = sq;
                5: h = (^{typ, sq}) ^ flip[4];
                default: h = 1'b0;
            endcase
            for (int k = 0; k < 4; k++) begin
                if (c >= 1 && c <= LB) d[k] = pl[k*LB + LB - c];
                else if (c == LB + 1) d[k] = (^pl[k*LB +: LB]) ^ flip[k];
            end
            set_pins(h, d);
        end
    endtask

    task automatic tail(input string tag, input logic [6:0] exp);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 3) chk({tag, " pulse"}, 32'(pulses), 32'(exp));
            else        chk({tag, " quiet"}, 32'(pulses), 32'(P_NONE));
            set_pins(1'b0, 4'b0000);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_pins(1'b0, 4'b0000);
        repeat (3) @(negedge clk);
        chk("reset pulses", 32'(pulses), 32'(P_NONE));
        chk("reset payload", payload, 32'h0);
        chk("reset errcnt", 32'(error_count), 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        send_frame(3'd5, 1'b0, 32'hA53CFF01, 5'b00000, 10);
        tail("data new", P_DV | P_SA);
        chk("data payload", payload, 32'hA53CFF01);
        chk("data ackseq", 32'(send_ack_seqNum), 32'h0);

        send_frame(3'd5, 1'b0, 32'hA53CFF01, 5'b00000, 10);
        tail("data dup", P_SA);
        chk("dup payload", payload, 32'hA53CFF01);
        chk("dup ackseq", 32'(send_ack_seqNum), 32'h0);

        send_frame(3'd5, 1'b1, 32'h0BADF00D, 5'b00000, 10);
        tail("data seq1", P_DV | P_SA);
        chk("seq1 payload", payload, 32'h0BADF00D);
        chk("seq1 ackseq", 32'(send_ack_seqNum), 32'h1);

        send_frame(3'd3, 1'b1, 32'h0, 5'b00000, 10);
        tail("ack", P_ACK);
        chk("ack seq", 32'(ack_seqNum), 32'h1);

        send_frame(3'd1, 1'b0, 32'h0, 5'b00000, 10);
        tail("ready", P_READY);
        chk("ack seq held", 32'(ack_seqNum), 32'h1);

        send_frame(3'd2, 1'b1, 32'h12345678, 5'b00000, 10);
        tail("game lost", P_GL);

        send_frame(3'd4, 1'b0, 32'h00000005, 5'b00001, 10);
        tail("lane0 parity", P_ERR);
        chk("errcnt 1", 32'(error_count), 32'h1);
        chk("garbage untouched", 32'(garbage), 32'h0);

        send_frame(3'd7, 1'b0, 32'h0, 5'b00000, 10);
        tail("type 7", P_ERR);
        chk("errcnt 2", 32'(error_count), 32'h2);

        send_frame(3'd5, 1'b0, 32'hFFFF0000, 5'b10000, 10);
        tail("hdr parity", P_ERR);
        chk("errcnt 3", 32'(error_count), 32'h3);
        chk("hdr err payload", payload, 32'h0BADF00D);

        send_frame(3'd4, 1'b0, 32'h00000003, 5'b00000, 10);
        send_frame(3'd4, 1'b1, 32'h00000006, 5'b00000, 10);
        chk("b2b first before", 32'(snap1), 32'(P_NONE));
        chk("b2b first pulse", 32'(snap2), 32'(P_GV | P_SA));
        chk("b2b first after", 32'(snap3), 32'(P_NONE));
        chk("b2b first garbage", 32'(snap_gbg), 32'h3);
        tail("b2b second", P_GV | P_SA);
        chk("b2b second garbage", 32'(garbage), 32'h6);
        chk("b2b second ackseq", 32'(send_ack_seqNum), 32'h1);

        send_frame(3'd5, 1'b0, 32'hDEADBEEF, 5'b00000, 6);
        @(negedge clk);
        rst = 1'b1;
        set_pins(1'b0, 4'b0000);
        @(negedge clk);
        chk("midrst pulses", 32'(pulses), 32'(P_NONE));
        chk("midrst payload", payload, 32'h0);
        chk("midrst garbage", 32'(garbage), 32'h0);
        chk("midrst errcnt", 32'(error_count), 32'h0);
        chk("midrst ackseq", 32'(ack_seqNum), 32'h0);
        chk("midrst sendseq", 32'(send_ack_seqNum), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk("post-rst quiet", 32'(pulses), 32'(P_NONE));
        end

        send_frame(3'd1, 1'b1, 32'h0, 5'b00000, 10);
        tail("ready after rst", P_READY);

        send_frame(3'd5, 1'b1, 32'h12345678, 5'b00000, 10);
        tail("seq_valid cleared", P_DV | P_SA);
        chk("after rst payload", payload, 32'h12345678);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
